// File: rtl/st_order_scheduler.sv
// Round-robin scheduler: grants one requester, then emits req_len order tokens carrying its stream id.
// Latency: request accepted in cycle N, first token valid in cycle N+1; back-to-back packets have no bubble.
// Backpressure: order_valid/order_data held until order_ready; no new grant until the last token's handshake.
// Optional: define ST_ORDER_SCHED_STATS_EN to add per-stream 32-bit token counters (stat_tokens).
module st_order_scheduler #(
   parameter int NB_IN     = 4,
   parameter int LEN_WIDTH = 8,
   localparam int IDW      = $clog2(NB_IN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NB_IN-1:0]     req_valid,
   output logic [NB_IN-1:0]     req_ready,
   input  logic [LEN_WIDTH-1:0] req_len [NB_IN],
   output logic                 order_valid,
   input  logic                 order_ready,
   output logic [IDW-1:0]       order_data,
`ifdef ST_ORDER_SCHED_STATS_EN
   output logic [31:0]          stat_tokens [NB_IN],
`endif
   output logic                 busy
);

   generate
      if (NB_IN < 2 || (NB_IN & (NB_IN - 1)) != 0) begin : g_bad_nb_in
         $error("st_order_scheduler: NB_IN must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic {IDLE, EMIT} state_t;

   state_t               state, state_n;
   logic [IDW-1:0]       cur_id, cur_id_n;
   logic [LEN_WIDTH-1:0] remaining, remaining_n;
   logic [IDW-1:0]       ptr, ptr_n;
   logic                 order_valid_n;
   logic [IDW-1:0]       order_data_n;

   logic                 handshake;
   logic                 last_token;
   logic                 arb_active;
   logic                 found;
   logic [IDW-1:0]       winner;
   logic [IDW-1:0]       idx;
   logic                 accept;

   assign handshake  = order_valid & order_ready;
   assign last_token = (state == EMIT) & handshake & (remaining == LEN_WIDTH'(1));
   assign arb_active = (state == IDLE) | last_token;
   assign accept     = arb_active & found;

   // Round-robin search starting at ptr; first valid requester wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NB_IN; k++) begin
         idx = ptr + IDW'(k);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // One-hot grant; gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      req_ready = '0;
      if (accept && rst_n) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Next-state: token countdown in EMIT, then grant handling (which may overlap the last token).
   always_comb begin
      state_n       = state;
      cur_id_n      = cur_id;
      remaining_n   = remaining;
      ptr_n         = ptr;
      order_valid_n = order_valid;
      order_data_n  = order_data;
      if (state == EMIT) begin
         order_data_n = cur_id;
         if (handshake) begin
            remaining_n = remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
               state_n       = IDLE;
               order_valid_n = 1'b0;
            end
         end
      end
      if (accept) begin
         cur_id_n    = winner;
         ptr_n       = winner + IDW'(1);
         remaining_n = req_len[winner];
         if (req_len[winner] != '0) begin
            state_n       = EMIT;
            order_valid_n = 1'b1;
            order_data_n  = winner;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cur_id      <= '0;
         remaining   <= '0;
         ptr         <= '0;
         order_valid <= 1'b0;
         order_data  <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         cur_id      <= cur_id_n;
         remaining   <= remaining_n;
         ptr         <= ptr_n;
         order_valid <= order_valid_n;
         order_data  <= order_data_n;
         busy        <= (state_n == EMIT);
      end
   end

`ifdef ST_ORDER_SCHED_STATS_EN
   // Per-stream token counters, bumped on each order handshake; wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB_IN; i++) stat_tokens[i] <= '0;
      end else if (handshake) begin
         for (int i = 0; i < NB_IN; i++) begin
            if (order_data == IDW'(i)) stat_tokens[i] <= stat_tokens[i] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_st_order_scheduler.sv
// Directed bench for st_order_scheduler: single packet, round-robin, backpressure,
// zero-length grant, async reset mid-packet, and (with the stats macro) token counters.
// Expected values are hand-computed constants; a negedge monitor collects tokens.
module tb_st_order_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_valid;
   logic [3:0] req_ready;
   logic [7:0] req_len [4];
   logic       order_valid;
   logic       order_ready;
   logic [1:0] order_data;
   logic       busy;
`ifdef ST_ORDER_SCHED_STATS_EN
   logic [31:0] stat_tokens [4];
`endif

   st_order_scheduler #(.NB_IN(4), .LEN_WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_len     (req_len),
      .order_valid (order_valid),
      .order_ready (order_ready),
      .order_data  (order_data),
`ifdef ST_ORDER_SCHED_STATS_EN
      .stat_tokens (stat_tokens),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int   tokens [$];
   int   stamps [$];
   int   stall_viol = 0;
   int   stall_cnt = 0;
   logic prev_stall = 1'b0;
   logic [1:0] prev_od = '0;

   always @(posedge clk) cyc++;

   // Token collector and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!order_valid || order_data != prev_od)) stall_viol++;
         if (order_valid && !order_ready) stall_cnt++;
         prev_stall = order_valid && !order_ready;
         prev_od    = order_data;
         if (order_valid && order_ready) begin
            tokens.push_back(int'(order_data));
            stamps.push_back(cyc);
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      tokens.delete();
      stamps.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int early;
      rst_n       = 1'b0;
      req_valid   = 4'hF;
      order_ready = 1'b0;
      for (int i = 0; i < 4; i++) req_len[i] = 8'd1;
      #3;
      check("rst_order_valid", int'(order_valid), 0);
      check("rst_order_data", int'(order_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_req_ready", int'(req_ready), 0);
      req_valid = 4'h0;
      tick();
      tick();
      rst_n = 1'b1;

      // Single packet: input 2, len 3.
      clear_mon();
      req_valid   = 4'b0100;
      req_len[2]  = 8'd3;
      order_ready = 1'b1;
      #1;
      check("t1_grant", int'(req_ready), 4'b0100);
      tick();
      check("t1_grant_pulse", int'(req_ready), 0);
      check("t1_busy", int'(busy), 1);
      req_valid = 4'b0000;
      repeat (5) tick();
      check("t1_ntok", tokens.size(), 3);
      for (int i = 0; i < tokens.size(); i++) check("t1_id", tokens[i], 2);
      if (stamps.size() == 3) check("t1_contig", stamps[2] - stamps[0], 2);
      check("t1_end_valid", int'(order_valid), 0);
      check("t1_end_busy", int'(busy), 0);

      // Round-robin from ptr 0, len 1 each.
      do_reset();
      clear_mon();
      for (int i = 0; i < 4; i++) req_len[i] = 8'd1;
      req_valid = 4'hF;
      repeat (8) tick();
      req_valid = 4'h0;
      repeat (4) tick();
      check("t2_ntok", tokens.size(), 8);
      for (int i = 0; i < tokens.size(); i++) check("t2_id", tokens[i], i % 4);
      if (stamps.size() == 8) check("t2_contig", stamps[7] - stamps[0], 7);

      // Backpressure: input 1 len 4, ready pattern 1,0,0,1,1,0,1.
      clear_mon();
      stall_viol  = 0;
      stall_cnt   = 0;
      early       = 0;
      order_ready = 1'b0;
      req_valid   = 4'b0010;
      req_len[1]  = 8'd4;
      tick();
      req_valid  = 4'b0100;
      req_len[2] = 8'd0;
      for (int i = 0; i < 7; i++) begin
         order_ready = pat[i][0];
         #1;
         if (req_ready != 4'b0000 && !(tokens.size() == 3 && order_ready)) early++;
         tick();
      end
      req_valid   = 4'b0000;
      order_ready = 1'b1;
      repeat (3) tick();
      check("t3_ntok", tokens.size(), 4);
      for (int i = 0; i < tokens.size(); i++) check("t3_id", tokens[i], 1);
      check("t3_stall_stable", stall_viol, 0);
      check("t3_stall_cycles", stall_cnt, 3);
      check("t3_early_ready", early, 0);

      // Zero length: input 3 len 0, then input 0 len 2; ptr must land on 1.
      clear_mon();
      do_reset();
      req_len[0] = 8'd1;
      req_len[1] = 8'd1;
      req_len[2] = 8'd1;
      req_len[3] = 8'd1;
      req_valid  = 4'b0010;
      #1;
      tick();
      req_valid  = 4'b0100;
      tick();
      req_valid  = 4'b0000;
      repeat (3) tick();
      clear_mon();
      req_valid  = 4'b1000;
      req_len[3] = 8'd0;
      #1;
      check("t4_zero_grant", int'(req_ready), 4'b1000);
      tick();
      check("t4_zero_novalid", int'(order_valid), 0);
      check("t4_zero_idle", int'(busy), 0);
      req_valid  = 4'b0001;
      req_len[0] = 8'd2;
      #1;
      check("t4_grant0", int'(req_ready), 4'b0001);
      tick();
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) req_len[i] = 8'd1;
      #1;
      check("t4_mid_noready", int'(req_ready), 0);
      tick();
      #1;
      check("t4_next_winner", int'(req_ready), 4'b0010);
      req_valid = 4'h0;
      repeat (4) tick();
      check("t4_ntok", tokens.size(), 2);
      for (int i = 0; i < tokens.size(); i++) check("t4_id", tokens[i], 0);

      // Async reset after 2 of 5 tokens on input 1 (ptr is 1 here).
      clear_mon();
      req_valid  = 4'b0010;
      req_len[1] = 8'd5;
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      req_valid = 4'hF;
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", int'(order_valid), 0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_ready", int'(req_ready), 0);
      tick();
      tick();
      check("t5_ntok", tokens.size(), 2);
      for (int i = 0; i < 4; i++) req_len[i] = 8'd1;
      rst_n = 1'b1;
      #1;
      check("t5_fresh_grant", int'(req_ready), 4'b0001);
      tick();
      req_valid = 4'h0;
      check("t5_fresh_valid", int'(order_valid), 1);
      check("t5_fresh_id", int'(order_data), 0);
      repeat (3) tick();

`ifdef ST_ORDER_SCHED_STATS_EN
      // Stats: 7 tokens on id 1, 5 on id 2.
      do_reset();
      req_len[1] = 8'd7;
      req_len[2] = 8'd5;
      req_valid  = 4'b0110;
      tick();
      req_valid  = 4'b0100;
      repeat (7) tick();
      req_valid  = 4'b0000;
      repeat (8) tick();
      check("st_id0", int'(stat_tokens[0]), 0);
      check("st_id1", int'(stat_tokens[1]), 7);
      check("st_id2", int'(stat_tokens[2]), 5);
      check("st_id3", int'(stat_tokens[3]), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
